// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction fetch controller for a combinational instruction ROM.
// Holds the fetch PC and drives the ROM address. Read data goes into a small prefetch FIFO,
// which decode drains over a valid/ready handshake. A redirect flushes the FIFO and restarts
// fetch at a new PC. Out-of-range and misaligned fetches are tagged as faults and park the
// fetcher until the next redirect.
// Optional feature: define IFETCH_PERF_EN to add the perf_instr_o / perf_bubble_o counters.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ROM_SIZE = 1024,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        fault_o,
  input  logic        instr_ready_i
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_instr_o,
  output logic [31:0] perf_bubble_o
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] fifo_instr_q [DEPTH];
  logic [31:0] fifo_pc_q    [DEPTH];
  logic        fifo_fault_q [DEPTH];

  logic        pop;
  logic        push;
  logic        full;
  logic        bad_addr;
  logic [31:0] push_instr;

  assign imem_addr_o = fetch_pc_q;

  // Head outputs come straight from storage; masking with valid keeps them zero when empty.
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? fifo_instr_q[rd_ptr_q] : 32'h0;
  assign instr_pc_o    = instr_valid_o ? fifo_pc_q[rd_ptr_q] : 32'h0;
  assign fault_o       = instr_valid_o & fifo_fault_q[rd_ptr_q];

  assign full       = (count_q == CW'(DEPTH));
  assign pop        = instr_valid_o & instr_ready_i;
  assign bad_addr   = (fetch_pc_q >= ROM_SIZE) || (fetch_pc_q[1:0] != 2'b00);
  assign push       = (state_q == ST_FETCH) && fetch_en_i && !redirect_i && (!full || pop);
  assign push_instr = bad_addr ? 32'h0 : imem_rdata_i;

  // Next-state for PC, FSM and FIFO bookkeeping; redirect overrides both push and pop.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
      state_d    = ST_FETCH;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (bad_addr) begin
          // Fault entry parks the fetcher on the offending PC until redirected.
          state_d = ST_FAULT;
        end else begin
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      state_q    <= ST_FETCH;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO payload storage; contents are only meaningful below count_q, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= push_instr;
      fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
      fifo_fault_q[wr_ptr_q] <= bad_addr;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_instr_q;
  logic [31:0] perf_bubble_q;

  assign perf_instr_o  = perf_instr_q;
  assign perf_bubble_o = perf_bubble_q;

  // Accepted-instruction and decode-starved-cycle counters; pops killed by redirect are not counted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_instr_q  <= 32'h0;
      perf_bubble_q <= 32'h0;
    end else begin
      if (pop && !redirect_i) begin
        perf_instr_q <= perf_instr_q + 32'd1;
      end
      if (instr_ready_i && !instr_valid_o) begin
        perf_bubble_q <= perf_bubble_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed self-checking bench for ifetch_ctrl with a combinational ROM model.
// Perf counter checks are compiled in when IFETCH_PERF_EN is defined.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fault;
  logic        ready = 1'b0;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_instr;
  logic [31:0] perf_bubble;
`endif

  int checks = 0;
  int fails  = 0;

  logic [31:0] exp_words [4] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};

  ifetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .ROM_SIZE (1024),
    .DEPTH    (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .fetch_en_i    (fetch_en),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .fault_o       (fault),
    .instr_ready_i (ready)
`ifdef IFETCH_PERF_EN
    ,
    .perf_instr_o  (perf_instr),
    .perf_bubble_o (perf_bubble)
`endif
  );

  always #5 clk = ~clk;

  // ROM model: first four words from the test plan, address-tagged words elsewhere.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   rom_word = 32'h0000_0013;
      32'h4:   rom_word = 32'h0010_0093;
      32'h8:   rom_word = 32'h0020_0113;
      32'hC:   rom_word = 32'h0030_0193;
      default: rom_word = {16'hC0DE, a[15:0]};
    endcase
  endfunction

  assign imem_rdata = rom_word(imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for one edge; the next step is the first non-reset edge.
  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    redirect = 1'b0;
    fetch_en = 1'b1;
    ready = rdy;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ready = 1'b1;
    step();
    step();
    checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b want 0", fault); end
    checks++; if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
    checks++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_sequential();
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL seq_valid[%0d]: got %b want 1", i, instr_valid); end
      checks++; if (instr_pc !== 32'(4 * i)) begin fails++; $display("FAIL seq_pc[%0d]: got %h want %h", i, instr_pc, 32'(4 * i)); end
      checks++; if (instr !== exp_words[i]) begin fails++; $display("FAIL seq_instr[%0d]: got %h want %h", i, instr, exp_words[i]); end
      checks++; if (fault !== 1'b0) begin fails++; $display("FAIL seq_fault[%0d]: got %b want 0", i, fault); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step();
    checks++; if (imem_addr !== 32'h8) begin fails++; $display("FAIL bp_addr_hold: got %h want 8", imem_addr); end
    checks++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) begin fails++; $display("FAIL bp_head: got %h/%b want 0/1", instr_pc, instr_valid); end
    ready = 1'b1;
    step();
    checks++; if (instr_pc !== 32'h4 || instr_valid !== 1'b1) begin fails++; $display("FAIL bp_rel1: got %h/%b want 4/1", instr_pc, instr_valid); end
    checks++; if (imem_addr !== 32'hC) begin fails++; $display("FAIL bp_full_push: got %h want c", imem_addr); end
    step();
    checks++; if (instr_pc !== 32'h8 || instr_valid !== 1'b1) begin fails++; $display("FAIL bp_rel2: got %h/%b want 8/1", instr_pc, instr_valid); end
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    step(); step(); step();
    checks++; if (instr_pc !== 32'h8) begin fails++; $display("FAIL rd_pre_head: got %h want 8", instr_pc); end
    ready = 1'b0;
    step(); step();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    ready = 1'b1;
    step();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rd_flush: valid got %b want 0 (pc %h)", instr_valid, instr_pc); end
    checks++; if (imem_addr !== 32'h40) begin fails++; $display("FAIL rd_addr: got %h want 40", imem_addr); end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin fails++; $display("FAIL rd_first: got %b/%h want 1/40", instr_valid, instr_pc); end
    checks++; if (instr !== rom_word(32'h40)) begin fails++; $display("FAIL rd_instr: got %h want %h", instr, rom_word(32'h40)); end
    step();
    checks++; if (instr_pc !== 32'h44) begin fails++; $display("FAIL rd_second: got %h want 44", instr_pc); end
  endtask

  task automatic test_fault_end();
    ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h3F8;
    step();
    redirect = 1'b0;
    step();
    checks++; if (instr_pc !== 32'h3F8 || fault !== 1'b0) begin fails++; $display("FAIL end_3f8: got %h/%b want 3f8/0", instr_pc, fault); end
    step();
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h400) begin fails++; $display("FAIL end_pc: got %b/%h want 1/400", instr_valid, instr_pc); end
    checks++; if (fault !== 1'b1) begin fails++; $display("FAIL end_fault: got %b want 1", fault); end
    checks++; if (instr !== 32'h0) begin fails++; $display("FAIL end_instr: got %h want 0", instr); end
    step();
    step();
    checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL end_nopush: valid got %b want 0", instr_valid); end
    checks++; if (imem_addr !== 32'h400) begin fails++; $display("FAIL end_addr: got %h want 400", imem_addr); end
    redirect = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || fault !== 1'b0) begin fails++; $display("FAIL end_resume: got %b/%h/%b want 1/0/0", instr_valid, instr_pc, fault); end
    checks++; if (instr !== 32'h0000_0013) begin fails++; $display("FAIL end_resume_instr: got %h want 00000013", instr); end
  endtask

  task automatic test_misaligned();
    ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h22;
    step();
    redirect = 1'b0;
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h22 || fault !== 1'b1) begin fails++; $display("FAIL mis_entry: got %b/%h/%b want 1/22/1", instr_valid, instr_pc, fault); end
    checks++; if (instr !== 32'h0) begin fails++; $display("FAIL mis_instr: got %h want 0", instr); end
    step();
    step();
    checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL mis_nopush: valid got %b want 0", instr_valid); end
    checks++; if (imem_addr !== 32'h22) begin fails++; $display("FAIL mis_addr: got %h want 22", imem_addr); end
  endtask

  task automatic test_fetch_en();
    ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    fetch_en = 1'b0;
    step(); step(); step();
    checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL fen_valid: got %b want 0", instr_valid); end
    checks++; if (imem_addr !== 32'h10) begin fails++; $display("FAIL fen_addr: got %h want 10", imem_addr); end
    fetch_en = 1'b1;
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h10) begin fails++; $display("FAIL fen_resume: got %b/%h want 1/10", instr_valid, instr_pc); end
  endtask

  task automatic test_reset_mid_stream();
    ready = 1'b1;
    step();
    rst = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h80;
    step();
    checks++; if (instr_valid !== 1'b0 || fault !== 1'b0) begin fails++; $display("FAIL mid_valid_fault: got %b/%b want 0/0", instr_valid, fault); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin fails++; $display("FAIL mid_head: got %h/%h want 0/0", instr, instr_pc); end
    checks++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL mid_addr_reset_wins: got %h want 0", imem_addr); end
    redirect = 1'b0;
    rst = 1'b0;
  endtask

`ifdef IFETCH_PERF_EN
  task automatic test_perf();
    do_reset(1'b0);
    step();
    ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    step();
    for (int i = 0; i < 5; i++) step();
    checks++; if (perf_instr !== 32'd10) begin fails++; $display("FAIL perf_instr: got %0d want 10", perf_instr); end
    checks++; if (perf_bubble !== 32'd1) begin fails++; $display("FAIL perf_bubble: got %0d want 1", perf_bubble); end
    rst = 1'b1;
    step();
    checks++; if (perf_instr !== 32'd0 || perf_bubble !== 32'd0) begin fails++; $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_instr, perf_bubble); end
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_fault_end();
    test_misaligned();
    test_fetch_en();
    test_reset_mid_stream();
`ifdef IFETCH_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
